// File: rtl/seven_seg_scan.sv
// Time-multiplexed DIGITS-wide hex display driver: prescaled digit scan, frame-synchronous
// value updates, leading-zero blanking, per-digit decimal points and a dead cycle per slot.
module seven_seg_scan #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);
  localparam int   PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int   IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [PW-1:0]             pcnt;
  logic [IW-1:0]             idx;
  logic [DIGITS-1:0][3:0]    disp_val, pend_val;
  logic [DIGITS-1:0]         disp_dp, pend_dp;
  logic                      pend_valid;
  logic                      slot_end, boundary;
  logic [DIGITS-1:0]         zhi;
  logic                      acc, blank;
  logic [3:0]                nib;
  logic [6:0]                seg_l;
  logic                      dp_l;
  logic [DIGITS-1:0]         an_l;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  assign slot_end = (pcnt == PW'(REFRESH_DIV - 1));
  assign boundary = slot_end && (idx == IW'(DIGITS - 1));
  assign nib      = disp_val[idx];

  // zhi[i]: displayed nibbles i..DIGITS-1 are all zero
  always_comb begin
    zhi = '0;
    acc = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc    = acc & (disp_val[i] == 4'h0);
      zhi[i] = acc;
    end
  end

  assign blank = (BLANK_LEADING != 0) && (idx != '0) && zhi[idx];

  always_comb begin
    an_l  = '0;
    seg_l = '0;
    dp_l  = 1'b0;
    if (enable && pcnt != '0) begin
      an_l[idx] = 1'b1;
      if (!blank) seg_l = glyph(nib);
      dp_l = disp_dp[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt       <= '0;
      idx        <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      seg        <= {7{SEG_INV}};
      dp_out     <= SEG_INV;
      an         <= {DIGITS{AN_INV}};
      frame      <= 1'b0;
    end else begin
      pcnt <= slot_end ? '0 : pcnt + PW'(1);
      if (slot_end) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);

      // a load landing on the boundary bypasses the pending stage
      if (load && boundary) begin
        disp_val   <= value;
        disp_dp    <= dp;
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_val   <= value;
        pend_dp    <= dp;
        pend_valid <= 1'b1;
      end else if (boundary && pend_valid) begin
        disp_val   <= pend_val;
        disp_dp    <= pend_dp;
        pend_valid <= 1'b0;
      end

      seg    <= seg_l ^ {7{SEG_INV}};
      dp_out <= dp_l ^ SEG_INV;
      an     <= an_l ^ {DIGITS{AN_INV}};
      frame  <= boundary;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan (DIGITS=4, REFRESH_DIV=4); three instances cover
// default, no-blanking and active-low-segment builds off shared stimulus.
module tb_seven_seg_scan;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0, enable = 1'b1;
  logic [6:0]  seg, seg_nb, seg_al;
  logic        dp_out, dp_nb, dp_al;
  logic [3:0]  an, an_nb, an_al;
  logic        frame, fr_nb, fr_al;
  int          pass_cnt = 0, tot_cnt = 0;

  always #5 clk = ~clk;

  seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)) u_main (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .enable(enable),
    .seg(seg), .dp_out(dp_out), .an(an), .frame(frame));
  seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .BLANK_LEADING(0)) u_nb (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .enable(enable),
    .seg(seg_nb), .dp_out(dp_nb), .an(an_nb), .frame(fr_nb));
  seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)) u_al (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .enable(enable),
    .seg(seg_al), .dp_out(dp_al), .an(an_al), .frame(fr_al));

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] g [0:3];
    int d; logic lit; logic [3:0] oh, ea; logic [6:0] es;
    step(2);
    tot_cnt++;
    if (an !== 4'hF || seg !== 7'h00 || dp_out !== 1'b0 || frame !== 1'b0 || seg_al !== 7'h7F || dp_al !== 1'b1)
      $display("FAIL reset_state: an=%b seg=%h dp=%b frame=%b seg_al=%h dp_al=%b, want 1111 00 0 0 7f 1",
               an, seg, dp_out, frame, seg_al, dp_al);
    else pass_cnt++;
    rst = 1'b0; value = 16'h1234; dp = 4'h0; load = 1'b1;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) g = '{7'h3F, 7'h00, 7'h00, 7'h00};
      else        g = '{7'h66, 7'h4F, 7'h5B, 7'h06};
      for (int e = 1; e <= 16; e++) begin
        @(negedge clk);
        load = 1'b0;
        d = (e - 1) / 4; lit = ((e - 1) % 4) != 0; oh = 4'b0001 << d;
        ea = lit ? ~oh : 4'hF; es = lit ? g[d] : 7'h00;
        tot_cnt++;
        if (an !== ea || seg !== es || dp_out !== 1'b0 || frame !== (e == 16))
          $display("FAIL first_scan f=%0d e=%0d: an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=0 frame=%b",
                   f, e, an, seg, dp_out, frame, ea, es, e == 16);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [6:0] g [0:3]; logic [6:0] gn [0:3];
    int d; logic lit; logic [3:0] oh, ea; logic [6:0] es, en;
    g  = '{7'h3F, 7'h77, 7'h00, 7'h00};
    gn = '{7'h3F, 7'h77, 7'h3F, 7'h3F};
    step(15); drive_load(16'h00A0, 4'h0);
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      d = (e - 1) / 4; lit = ((e - 1) % 4) != 0; oh = 4'b0001 << d;
      ea = lit ? ~oh : 4'hF; es = lit ? g[d] : 7'h00; en = lit ? gn[d] : 7'h00;
      tot_cnt++;
      if (an !== ea || seg !== es || an_nb !== ea || seg_nb !== en || dp_nb !== 1'b0 || fr_nb !== (e == 16))
        $display("FAIL leading_zeros e=%0d: an=%b seg=%h an_nb=%b seg_nb=%h dp_nb=%b, want an=%b seg=%h seg_nb=%h dp_nb=0",
                 e, an, seg, an_nb, seg_nb, dp_nb, ea, es, en);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_dp();
    logic [6:0] g [0:3];
    int d; logic lit, edp; logic [3:0] oh, ea; logic [6:0] es;
    g = '{7'h3F, 7'h00, 7'h00, 7'h00};
    step(15); drive_load(16'h0000, 4'b0100);
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      d = (e - 1) / 4; lit = ((e - 1) % 4) != 0; oh = 4'b0001 << d;
      ea = lit ? ~oh : 4'hF; es = lit ? g[d] : 7'h00; edp = lit && (d == 2);
      tot_cnt++;
      if (an !== ea || seg !== es || dp_out !== edp || frame !== (e == 16))
        $display("FAIL zero_dp e=%0d: an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=%b",
                 e, an, seg, dp_out, frame, ea, es, edp);
      else pass_cnt++;
    end
  endtask

  task automatic test_tear_free();
    logic [6:0] g [0:3];
    int d; logic lit, edp; logic [3:0] oh, ea; logic [6:0] es;
    g = '{7'h3F, 7'h00, 7'h00, 7'h00};
    step(6); drive_load(16'hFFFF, 4'h0);
    // remainder of the frame keeps the old value (0000, dp on digit 2)
    for (int e = 8; e <= 16; e++) begin
      @(negedge clk);
      d = (e - 1) / 4; lit = ((e - 1) % 4) != 0; oh = 4'b0001 << d;
      ea = lit ? ~oh : 4'hF; es = lit ? g[d] : 7'h00; edp = lit && (d == 2);
      tot_cnt++;
      if (an !== ea || seg !== es || dp_out !== edp || frame !== (e == 16))
        $display("FAIL tear_old e=%0d: an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=%b",
                 e, an, seg, dp_out, frame, ea, es, edp);
      else pass_cnt++;
    end
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      d = (e - 1) / 4; lit = ((e - 1) % 4) != 0; oh = 4'b0001 << d;
      ea = lit ? ~oh : 4'hF; es = lit ? 7'h71 : 7'h00;
      tot_cnt++;
      if (an !== ea || seg !== es || dp_out !== 1'b0 || frame !== (e == 16))
        $display("FAIL tear_new e=%0d: an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=0",
                 e, an, seg, dp_out, frame, ea, es);
      else pass_cnt++;
    end
  endtask

  task automatic test_two_loads();
    int d; logic lit; logic [3:0] oh, ea; logic [6:0] es;
    step(2); drive_load(16'h1111, 4'h0);
    step(5); drive_load(16'h2222, 4'h0);
    step(7);
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      d = (e - 1) / 4; lit = ((e - 1) % 4) != 0; oh = 4'b0001 << d;
      ea = lit ? ~oh : 4'hF; es = lit ? 7'h5B : 7'h00;
      tot_cnt++;
      if (an !== ea || seg !== es || frame !== (e == 16))
        $display("FAIL two_loads e=%0d: an=%b seg=%h frame=%b, want an=%b seg=%h", e, an, seg, frame, ea, es);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_on_boundary();
    int d; logic lit; logic [3:0] oh, ea; logic [6:0] es;
    step(15); drive_load(16'h3333, 4'h0);
    tot_cnt++;
    if (frame !== 1'b1) $display("FAIL boundary_frame: frame=%b, want 1", frame);
    else pass_cnt++;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      d = (e - 1) / 4; lit = ((e - 1) % 4) != 0; oh = 4'b0001 << d;
      ea = lit ? ~oh : 4'hF; es = lit ? 7'h4F : 7'h00;
      tot_cnt++;
      if (an !== ea || seg !== es || frame !== (e == 16))
        $display("FAIL load_on_boundary e=%0d: an=%b seg=%h frame=%b, want an=%b seg=%h", e, an, seg, frame, ea, es);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable();
    int frames;
    frames = 0;
    enable = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      @(negedge clk);
      if (frame === 1'b1) frames++;
      tot_cnt++;
      if (an !== 4'hF || seg !== 7'h00 || dp_out !== 1'b0)
        $display("FAIL enable_off e=%0d: an=%b seg=%h dp=%b, want 1111 00 0", e, an, seg, dp_out);
      else pass_cnt++;
    end
    tot_cnt++;
    if (frames !== 2) $display("FAIL enable_frames: got %0d pulses, want 2", frames);
    else pass_cnt++;
    enable = 1'b1;
  endtask

  task automatic test_polarity();
    int d; logic lit; logic [3:0] oh, ea; logic [6:0] es, ea_s;
    step(15); drive_load(16'h8888, 4'h0);
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      d = (e - 1) / 4; lit = ((e - 1) % 4) != 0; oh = 4'b0001 << d;
      ea = lit ? ~oh : 4'hF; es = lit ? 7'h7F : 7'h00; ea_s = lit ? 7'h00 : 7'h7F;
      tot_cnt++;
      if (an_al !== ea || seg_al !== ea_s || dp_al !== 1'b1 || fr_al !== (e == 16) || seg !== es)
        $display("FAIL polarity e=%0d: an_al=%b seg_al=%h dp_al=%b seg=%h, want an=%b seg_al=%h dp_al=1 seg=%h",
                 e, an_al, seg_al, dp_al, seg, ea, ea_s, es);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    int d; logic lit; logic [3:0] oh, ea; logic [6:0] es;
    drive_load(16'h5555, 4'hF);
    step(5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tot_cnt++;
    if (an !== 4'hF || seg !== 7'h00 || dp_out !== 1'b0 || frame !== 1'b0 ||
        an_al !== 4'hF || seg_al !== 7'h7F || dp_al !== 1'b1)
      $display("FAIL async_reset: an=%b seg=%h dp=%b frame=%b an_al=%b seg_al=%h dp_al=%b, want 1111 00 0 0 1111 7f 1",
               an, seg, dp_out, frame, an_al, seg_al, dp_al);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    // neither the old 8888 nor the pending 5555 may reappear
    for (int e = 1; e <= 32; e++) begin
      @(negedge clk);
      d = ((e - 1) % 16) / 4; lit = ((e - 1) % 4) != 0; oh = 4'b0001 << d;
      ea = lit ? ~oh : 4'hF; es = (lit && d == 0) ? 7'h3F : 7'h00;
      tot_cnt++;
      if (an !== ea || seg !== es || dp_out !== 1'b0 || frame !== (e % 16 == 0))
        $display("FAIL after_reset e=%0d: an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=0 frame=%b",
                 e, an, seg, dp_out, frame, ea, es, e % 16 == 0);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_leading_zeros();
    test_zero_dp();
    test_tear_free();
    test_two_loads();
    test_load_on_boundary();
    test_enable();
    test_polarity();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
